ramio_arbiter: RTL and testbench
================================

# ramio_arbiter

Two-requester arbiter that shares the single `ramio` port between the CPU core (requester 0) and a secondary master (requester 1), such as a UART or DMA loader. Ownership lasts one enable-high period. Ownership passes round-robin on release. The owner's command path, and the path back to it, are pass-through, so the owner sees the same protocol as a direct `ramio` connection. The block sits between `core` and `ramio` at top level.

## Interface
- `FirstPriority`, default 0: requester that wins a simultaneous request after reset (0 or 1).
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `m0_enable` / `m1_enable`, in, 1 each: requester holds the port request.
- `m0_read_type` / `m1_read_type`, in, 3 each: ramio read type.
- `m0_write_type` / `m1_write_type`, in, 2 each: ramio write type.
- `m0_address` / `m1_address`, in, 32 each: byte address.
- `m0_data_in` / `m1_data_in`, in, 32 each: write data.
- `m0_data_out` / `m1_data_out`, out, 32 each: copy of `ramio_data_out`.
- `m0_data_out_ready` / `m1_data_out_ready`, out, 1 each: gated ready.
- `m0_busy` / `m1_busy`, out, 1 each: gated busy.
- `ramio_enable`, `ramio_read_type[2:0]`, `ramio_write_type[1:0]`, `ramio_address[31:0]`, `ramio_data_in[31:0]`, out: the downstream command.
- `ramio_data_out[31:0]`, `ramio_data_out_ready`, `ramio_busy`, in: the downstream response.
- `grant`, out, 2: one-hot current owner; 2'b00 when no requester owns the port.

## Operation
- FSM states are `Idle`, `Own0` and `Own1`. A priority pointer `prio` (1 bit) resets to `FirstPriority`.
- **`Idle`**
  - The arbiter acts only when `ramio_busy` = 0.
  - If exactly one `mX_enable` is high, the next state is `OwnX`.
  - If both are high, the next state is `Own[prio]`.
  - Otherwise the FSM stays in `Idle`.
- **`OwnX`**
  - All downstream command outputs are driven combinationally from requester X.
  - `mX_busy` = `ramio_busy` and `mX_data_out_ready` = `ramio_data_out_ready`.
  - The state is held while `mX_enable` = 1, including when type or address changes with enable held (store followed by fetch).
  - When `mX_enable` = 0, the downstream sees enable 0 that cycle. The next state is `Idle` and `prio` is set to the other requester.
- **Non-owner gating**
  - For a requester that is not the owner: `mY_data_out_ready` = 0.
  - `mY_busy` = 1 if `mY_enable` = 1, or if the FSM is not in `Idle`.
  - Otherwise `mY_busy` = 0. This lets an idle requester sample "not busy" before it raises enable, and guarantees that a waiting requester never mistakes the wait for write completion.
- **Outputs when no owner**
  - When no requester owns the port, `ramio_enable`, `ramio_read_type`, `ramio_write_type`, `ramio_address` and `ramio_data_in` are all 0.
- **Data and grant**
  - `m0_data_out` and `m1_data_out` always equal `ramio_data_out`; only the ready signal is gated.
  - `grant` is a registered decode of the state.
- **No preemption**
  - An owner keeps the port until it drops enable.
  - Starvation is bounded by one ownership period of the other requester, because `prio` flips on every release.
- **Illegal state**
  - An illegal state encoding returns the FSM to `Idle`.

## Timing
- **Reset values**
  - `ramio_enable`, types, address and `ramio_data_in` are all 0.
  - `grant` is 2'b00 and both `mX_data_out_ready` are 0.
  - `mX_busy` is 0 while `mX_enable` is low.
  - `prio` = `FirstPriority` and the state is `Idle`.
- **Arbitration latency**
  - Enable high in `Idle` with `ramio_busy` = 0 gives ownership at the next edge.
  - The downstream sees the command 1 cycle after the requester raises enable.
- **Owned path**
  - Zero-cycle pass-through in both directions; behaviour is cycle-identical to a direct connection.
- **Release to next grant**
  - Minimum gap is 2 cycles: the release cycle, then an `Idle` cycle.
  - `Idle` is extended while `ramio_busy` = 1, which lets a posted write drain.
- **Simultaneous events**
  - Release by X and a request by Y in the same cycle: Y is granted from `Idle` on the following edge.
  - A requester whose enable rises on the `Idle`→`Own` edge of the other requester waits.
- **Reset mid-operation**
  - Ownership is dropped immediately and asynchronously; outputs go to their reset values.
  - An interrupted transaction is not completed or replayed.

## Test plan
1. **Solo requester 0 read:** `m0_enable`=1, read_type=3'b111, address=0x100, `m1` idle.
   - `grant`=01 after 1 cycle and `ramio_address`=0x100.
   - A model response of 0xDEADBEEF with ready gives `m0_data_out`=0xDEADBEEF and `m0_data_out_ready`=1.
2. **Simultaneous requests after reset (`FirstPriority`=0):**
   - Requester 0 owns first; `m1_busy`=1 and `m1_data_out_ready`=0 throughout.
   - Requester 0 releases: requester 1 owns 2 cycles later.
   - Both request again: requester 0 wins (round-robin).
3. **Held-enable type change:** `m0` writes 0x12345678 to 0x40, then switches to a read of 0x44 with enable held.
   - No re-arbitration occurs and `grant` stays 01.
   - The downstream sees both commands back-to-back.
4. **Drain before grant:** `m1` drops enable while `ramio_busy`=1 for 3 more cycles and `m0` is requesting.
   - `m0` is granted only on the edge after `ramio_busy` falls.
5. **Busy semantics:**
   - With `m1` owning: idle `m0` (enable 0) sees `m0_busy`=1; after the FSM returns to `Idle`, `m0_busy`=0.
   - `m0` raises enable while `m1` owns: `m0_busy` stays 1 until `m0` is granted.
6. **Reset mid-ownership:** assert `rst_n`=0 while `grant`=10.
   - Outputs return to their reset values in the same cycle.
   - After release, the first simultaneous request is won by `FirstPriority`.

Source files
------------

// File: rtl/ramio_arbiter.sv
// Two-requester round-robin arbiter in front of the single ramio port.
// The owner sees a zero-cycle pass-through; the non-owner is held off with busy.
module ramio_arbiter #(
  parameter bit FirstPriority = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_enable,
  input  logic [2:0]  m0_read_type,
  input  logic [1:0]  m0_write_type,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_data_in,
  output logic [31:0] m0_data_out,
  output logic        m0_data_out_ready,
  output logic        m0_busy,

  input  logic        m1_enable,
  input  logic [2:0]  m1_read_type,
  input  logic [1:0]  m1_write_type,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_data_in,
  output logic [31:0] m1_data_out,
  output logic        m1_data_out_ready,
  output logic        m1_busy,

  output logic        ramio_enable,
  output logic [2:0]  ramio_read_type,
  output logic [1:0]  ramio_write_type,
  output logic [31:0] ramio_address,
  output logic [31:0] ramio_data_in,
  input  logic [31:0] ramio_data_out,
  input  logic        ramio_data_out_ready,
  input  logic        ramio_busy,

  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    Idle = 2'b00,
    Own0 = 2'b01,
    Own1 = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic [1:0]  grant_q, grant_d;

  // Requester-indexed views of the two command ports.
  logic [1:0]  req_en;
  logic [2:0]  req_rt   [2];
  logic [1:0]  req_wt   [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_din  [2];

  logic [1:0]  rsp_ready;
  logic [1:0]  rsp_busy;

  logic        own_valid;
  logic        own_sel;

  assign req_en      = {m1_enable, m0_enable};
  assign req_rt[0]   = m0_read_type;
  assign req_rt[1]   = m1_read_type;
  assign req_wt[0]   = m0_write_type;
  assign req_wt[1]   = m1_write_type;
  assign req_addr[0] = m0_address;
  assign req_addr[1] = m1_address;
  assign req_din[0]  = m0_data_in;
  assign req_din[1]  = m1_data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Idle;
      prio_q  <= FirstPriority;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      Idle: begin
        // Waiting for ramio_busy to fall lets a posted write drain first.
        if (!ramio_busy) begin
          if (req_en == 2'b11) begin
            state_d = prio_q ? Own1 : Own0;
          end else if (req_en[0]) begin
            state_d = Own0;
          end else if (req_en[1]) begin
            state_d = Own1;
          end
        end
      end
      Own0: begin
        if (!req_en[0]) begin
          state_d = Idle;
          prio_d  = 1'b1;
        end
      end
      Own1: begin
        if (!req_en[1]) begin
          state_d = Idle;
          prio_d  = 1'b0;
        end
      end
      default: state_d = Idle;
    endcase

    // grant_q therefore always mirrors the decode of state_q.
    grant_d = 2'b00;
    case (state_d)
      Own0:    grant_d = 2'b01;
      Own1:    grant_d = 2'b10;
      default: grant_d = 2'b00;
    endcase
  end

  always_comb begin
    own_valid = 1'b0;
    own_sel   = 1'b0;
    case (state_q)
      Own0: begin
        own_valid = 1'b1;
        own_sel   = 1'b0;
      end
      Own1: begin
        own_valid = 1'b1;
        own_sel   = 1'b1;
      end
      default: begin
        own_valid = 1'b0;
        own_sel   = 1'b0;
      end
    endcase
  end

  always_comb begin
    ramio_enable     = 1'b0;
    ramio_read_type  = 3'b000;
    ramio_write_type = 2'b00;
    ramio_address    = 32'h0;
    ramio_data_in    = 32'h0;
    if (own_valid) begin
      ramio_enable     = req_en[own_sel];
      ramio_read_type  = req_rt[own_sel];
      ramio_write_type = req_wt[own_sel];
      ramio_address    = req_addr[own_sel];
      ramio_data_in    = req_din[own_sel];
    end
  end

  // A waiting requester sees busy so it never reads the wait as write completion.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic is_owner;
    assign is_owner      = own_valid && (own_sel == 1'(gi));
    assign rsp_ready[gi] = is_owner & ramio_data_out_ready;
    assign rsp_busy[gi]  = is_owner ? ramio_busy
                                    : (req_en[gi] | (state_q != Idle));
  end

  assign m0_data_out       = ramio_data_out;
  assign m1_data_out       = ramio_data_out;
  assign m0_data_out_ready = rsp_ready[0];
  assign m1_data_out_ready = rsp_ready[1];
  assign m0_busy           = rsp_busy[0];
  assign m1_busy           = rsp_busy[1];
  assign grant             = grant_q;

endmodule

// File: tb/tb_ramio_arbiter.sv
// Bench for ramio_arbiter: a cycle table, hand-written corner sequences,
// then randomized traffic against an ownership/priority reference model.
module tb_ramio_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_enable, m1_enable;
  logic [2:0]  m0_read_type, m1_read_type;
  logic [1:0]  m0_write_type, m1_write_type;
  logic [31:0] m0_address, m1_address, m0_data_in, m1_data_in;
  logic [31:0] m0_data_out, m1_data_out;
  logic        m0_data_out_ready, m1_data_out_ready, m0_busy, m1_busy;
  logic        ramio_enable;
  logic [2:0]  ramio_read_type;
  logic [1:0]  ramio_write_type;
  logic [31:0] ramio_address, ramio_data_in, ramio_data_out;
  logic        ramio_data_out_ready, ramio_busy;
  logic [1:0]  grant;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ramio_arbiter #(.FirstPriority(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_enable(m0_enable), .m0_read_type(m0_read_type), .m0_write_type(m0_write_type),
    .m0_address(m0_address), .m0_data_in(m0_data_in), .m0_data_out(m0_data_out),
    .m0_data_out_ready(m0_data_out_ready), .m0_busy(m0_busy),
    .m1_enable(m1_enable), .m1_read_type(m1_read_type), .m1_write_type(m1_write_type),
    .m1_address(m1_address), .m1_data_in(m1_data_in), .m1_data_out(m1_data_out),
    .m1_data_out_ready(m1_data_out_ready), .m1_busy(m1_busy),
    .ramio_enable(ramio_enable), .ramio_read_type(ramio_read_type),
    .ramio_write_type(ramio_write_type), .ramio_address(ramio_address),
    .ramio_data_in(ramio_data_in), .ramio_data_out(ramio_data_out),
    .ramio_data_out_ready(ramio_data_out_ready), .ramio_busy(ramio_busy),
    .grant(grant)
  );

  typedef struct {
    bit        en0, en1, rbusy, rrdy;
    bit [1:0]  g;
    bit        ren;
    bit [31:0] raddr;
    bit        b0, b1, r0, r1;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(bit en0, bit en1, bit rbusy, bit rrdy, bit [1:0] g, bit ren,
                              bit [31:0] raddr, bit b0, bit b1, bit r0, bit r1);
    vec_t v;
    v.en0 = en0; v.en1 = en1; v.rbusy = rbusy; v.rrdy = rrdy;
    v.g = g; v.ren = ren; v.raddr = raddr;
    v.b0 = b0; v.b1 = b1; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_zero();
    m0_enable = 0; m1_enable = 0;
    m0_read_type = 0; m1_read_type = 0; m0_write_type = 0; m1_write_type = 0;
    m0_address = 0; m1_address = 0; m0_data_in = 0; m1_data_in = 0;
    ramio_data_out = 0; ramio_data_out_ready = 0; ramio_busy = 0;
  endtask

  // Reference model: who owns the port and who wins the next tie.
  int model_own;
  bit model_prio;

  task automatic check_model(input string tag);
    logic [31:0] e_addr, e_din;
    logic [2:0]  e_rt;
    logic [1:0]  e_wt, e_g;
    logic        e_en, e_b0, e_b1, e_r0, e_r1;
    e_en = 0; e_rt = 0; e_wt = 0; e_addr = 0; e_din = 0; e_g = 2'b00;
    if (model_own == 0) begin
      e_en = m0_enable; e_rt = m0_read_type; e_wt = m0_write_type;
      e_addr = m0_address; e_din = m0_data_in; e_g = 2'b01;
    end else if (model_own == 1) begin
      e_en = m1_enable; e_rt = m1_read_type; e_wt = m1_write_type;
      e_addr = m1_address; e_din = m1_data_in; e_g = 2'b10;
    end
    e_r0 = (model_own == 0) && ramio_data_out_ready;
    e_r1 = (model_own == 1) && ramio_data_out_ready;
    e_b0 = (model_own == 0) ? ramio_busy : (m0_enable || model_own != -1);
    e_b1 = (model_own == 1) ? ramio_busy : (m1_enable || model_own != -1);
    chk({tag, " grant"}, grant, e_g);
    chk({tag, " ramio_enable"}, ramio_enable, e_en);
    chk({tag, " ramio_read_type"}, ramio_read_type, e_rt);
    chk({tag, " ramio_write_type"}, ramio_write_type, e_wt);
    chk({tag, " ramio_address"}, ramio_address, e_addr);
    chk({tag, " ramio_data_in"}, ramio_data_in, e_din);
    chk({tag, " m0_busy"}, m0_busy, e_b0);
    chk({tag, " m1_busy"}, m1_busy, e_b1);
    chk({tag, " m0_ready"}, m0_data_out_ready, e_r0);
    chk({tag, " m1_ready"}, m1_data_out_ready, e_r1);
    chk({tag, " m0_data_out"}, m0_data_out, ramio_data_out);
    chk({tag, " m1_data_out"}, m1_data_out, ramio_data_out);
  endtask

  task automatic model_edge();
    if (model_own == -1) begin
      if (!ramio_busy) begin
        if (m0_enable && m1_enable) model_own = model_prio;
        else if (m0_enable) model_own = 0;
        else if (m1_enable) model_own = 1;
      end
    end else if ((model_own == 0 && !m0_enable) || (model_own == 1 && !m1_enable)) begin
      model_prio = (model_own == 0);
      model_own  = -1;
    end
  endtask

  initial begin
    // columns: en0 en1 rbusy rrdy | grant ren raddr | b0 b1 r0 r1
    vecs[0]  = mk(0, 0, 0, 0, 2'b00, 0, 32'h000, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 2'b00, 0, 32'h000, 1, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 1, 2'b01, 1, 32'h100, 0, 1, 1, 0);
    vecs[3]  = mk(0, 0, 0, 0, 2'b01, 0, 32'h100, 0, 1, 0, 0);
    vecs[4]  = mk(1, 1, 0, 0, 2'b00, 0, 32'h000, 1, 1, 0, 0);
    vecs[5]  = mk(1, 1, 0, 1, 2'b10, 1, 32'h200, 1, 0, 0, 1);
    vecs[6]  = mk(1, 0, 0, 0, 2'b10, 0, 32'h200, 1, 0, 0, 0);
    vecs[7]  = mk(1, 0, 0, 0, 2'b00, 0, 32'h000, 1, 0, 0, 0);
    vecs[8]  = mk(1, 1, 0, 1, 2'b01, 1, 32'h100, 0, 1, 1, 0);
    vecs[9]  = mk(0, 1, 1, 0, 2'b01, 0, 32'h100, 1, 1, 0, 0);
    vecs[10] = mk(0, 1, 1, 0, 2'b00, 0, 32'h000, 0, 1, 0, 0);
    vecs[11] = mk(0, 1, 1, 0, 2'b00, 0, 32'h000, 0, 1, 0, 0);
    vecs[12] = mk(0, 1, 0, 0, 2'b00, 0, 32'h000, 0, 1, 0, 0);
    vecs[13] = mk(0, 1, 0, 1, 2'b10, 1, 32'h200, 1, 0, 0, 1);
    vecs[14] = mk(0, 0, 0, 0, 2'b10, 0, 32'h200, 1, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 2'b00, 0, 32'h000, 0, 0, 0, 0);

    drive_zero();
    #1;
    chk("reset grant", grant, 2'b00);
    chk("reset ramio_enable", ramio_enable, 1'b0);
    chk("reset ramio_address", ramio_address, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table phase: requester 0 reads 0x100 (type 111), requester 1 reads 0x200 (type 010).
    m0_read_type = 3'b111; m0_address = 32'h100;
    m1_read_type = 3'b010; m1_address = 32'h200;
    for (int i = 0; i < 16; i++) begin
      logic [2:0] e_rt;
      m0_enable = vecs[i].en0;
      m1_enable = vecs[i].en1;
      ramio_busy = vecs[i].rbusy;
      ramio_data_out_ready = vecs[i].rrdy;
      ramio_data_out = 32'hDEADBEEF + i;
      #1;
      e_rt = (vecs[i].raddr == 32'h100) ? 3'b111 : (vecs[i].raddr == 32'h200) ? 3'b010 : 3'b000;
      chk($sformatf("vec%0d grant", i), grant, vecs[i].g);
      chk($sformatf("vec%0d ramio_enable", i), ramio_enable, vecs[i].ren);
      chk($sformatf("vec%0d ramio_address", i), ramio_address, vecs[i].raddr);
      chk($sformatf("vec%0d ramio_read_type", i), ramio_read_type, e_rt);
      chk($sformatf("vec%0d m0_busy", i), m0_busy, vecs[i].b0);
      chk($sformatf("vec%0d m1_busy", i), m1_busy, vecs[i].b1);
      chk($sformatf("vec%0d m0_ready", i), m0_data_out_ready, vecs[i].r0);
      chk($sformatf("vec%0d m1_ready", i), m1_data_out_ready, vecs[i].r1);
      chk($sformatf("vec%0d m0_data_out", i), m0_data_out, 32'hDEADBEEF + i);
      chk($sformatf("vec%0d m1_data_out", i), m1_data_out, 32'hDEADBEEF + i);
      @(negedge clk);
    end

    // Held-enable store followed by fetch: no re-arbitration.
    drive_zero();
    m0_enable = 1; m0_write_type = 2'b11; m0_address = 32'h40; m0_data_in = 32'h12345678;
    @(negedge clk);
    #1;
    chk("store grant", grant, 2'b01);
    chk("store ramio_enable", ramio_enable, 1'b1);
    chk("store write_type", ramio_write_type, 2'b11);
    chk("store address", ramio_address, 32'h40);
    chk("store data_in", ramio_data_in, 32'h12345678);
    @(negedge clk);
    m0_write_type = 2'b00; m0_read_type = 3'b111; m0_address = 32'h44;
    #1;
    chk("fetch grant", grant, 2'b01);
    chk("fetch ramio_enable", ramio_enable, 1'b1);
    chk("fetch read_type", ramio_read_type, 3'b111);
    chk("fetch write_type", ramio_write_type, 2'b00);
    chk("fetch address", ramio_address, 32'h44);
    @(negedge clk);
    #1;
    chk("fetch held grant", grant, 2'b01);
    @(negedge clk);
    m0_enable = 0;
    @(negedge clk);
    @(negedge clk);

    // m0 released last, so a tie would now go to m1 unless reset restores priority.
    m1_enable = 1; m1_address = 32'h300; ramio_data_out_ready = 1;
    @(negedge clk);
    #1;
    chk("pre-reset grant", grant, 2'b10);
    chk("pre-reset m1_ready", m1_data_out_ready, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid-reset grant", grant, 2'b00);
    chk("mid-reset ramio_enable", ramio_enable, 1'b0);
    chk("mid-reset ramio_address", ramio_address, 32'h0);
    chk("mid-reset m1_ready", m1_data_out_ready, 1'b0);
    chk("mid-reset m0_busy", m0_busy, 1'b0);
    @(negedge clk);
    m1_enable = 0; ramio_data_out_ready = 0;
    rst_n = 1'b1;
    @(negedge clk);
    m0_enable = 1; m1_enable = 1;
    @(negedge clk);
    #1;
    chk("post-reset tie grant", grant, 2'b01);
    chk("post-reset tie m1_busy", m1_busy, 1'b1);
    @(negedge clk);
    m0_enable = 0; m1_enable = 0;
    @(negedge clk);

    // Random phase from a fresh reset.
    drive_zero();
    rst_n = 1'b0;
    model_own = -1;
    model_prio = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 4) == 0) m0_enable = ~m0_enable;
      if ($urandom_range(0, 4) == 0) m1_enable = ~m1_enable;
      m0_read_type = 3'($urandom); m1_read_type = 3'($urandom);
      m0_write_type = 2'($urandom); m1_write_type = 2'($urandom);
      m0_address = $urandom; m1_address = $urandom;
      m0_data_in = $urandom; m1_data_in = $urandom;
      ramio_data_out = $urandom;
      ramio_data_out_ready = 1'($urandom);
      ramio_busy = ($urandom_range(0, 2) == 0);
      #1;
      check_model($sformatf("rnd%0d", c));
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
